// File: rtl/paddle_button_conditioner_if.sv
// ----------------------------------------------------------------------------
// paddle_button_conditioner_if
//
// Purpose:
//   Groups the button-side and paddle-side signals of the paddle button
//   conditioner so the block and its user connect through one bundle.
//
// Signals:
//   btn_up    raw, asynchronous, bouncing up button (1 = pressed)
//   btn_down  raw, asynchronous, bouncing down button (1 = pressed)
//   up        one-clock pulse: step paddle up
//   down      one-clock pulse: step paddle down
//   held      debounced button levels {down_db, up_db}
//
// Modports:
//   master  the side that owns the buttons and consumes the pulses
//   slave   the conditioner itself
// ----------------------------------------------------------------------------
interface paddle_button_conditioner_if;

    logic       btn_up;
    logic       btn_down;
    logic       up;
    logic       down;
    logic [1:0] held;

    modport master (
        output btn_up,
        output btn_down,
        input  up,
        input  down,
        input  held
    );

    modport slave (
        input  btn_up,
        input  btn_down,
        output up,
        output down,
        output held
    );

endinterface

// File: rtl/paddle_button_conditioner.sv
// ----------------------------------------------------------------------------
// paddle_button_conditioner
//
// Purpose:
//   Turns two raw push-buttons into up/down step commands for the paddle
//   controller. Each button is synchronised with two flops and debounced;
//   a debounced press then produces a single one-clock command pulse.
//   Holding a button auto-repeats the pulse at a fixed rate when the
//   PADDLE_AUTO_REPEAT_EN macro is defined; without it, every debounced
//   press produces exactly one pulse and the repeat counter does not exist.
//   Pressing both buttons together suppresses all pulses until both are
//   released.
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive stable cycles before a debounced level
//                    changes (>= 1)
//   REPEAT_DELAY     cycles from first pulse to first auto-repeat pulse
//                    (>= 1, only with PADDLE_AUTO_REPEAT_EN)
//   REPEAT_RATE      cycles between later auto-repeat pulses
//                    (>= 1, only with PADDLE_AUTO_REPEAT_EN)
//
// Ports:
//   clk    in   system clock, all logic on posedge
//   reset  in   asynchronous reset, active low (0 = reset asserted)
//   bus    slave modport of paddle_button_conditioner_if:
//            btn_up/btn_down in, up/down pulses out, held[1:0] out
//
// Configuration macro:
//   PADDLE_AUTO_REPEAT_EN  defined: hold-to-repeat enabled
//                          undefined: one pulse per debounced press
// ----------------------------------------------------------------------------
module paddle_button_conditioner #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
`ifdef PADDLE_AUTO_REPEAT_EN
    ,
    parameter logic [23:0] REPEAT_DELAY    = 24'd5000000,
    parameter logic [23:0] REPEAT_RATE     = 24'd2500000
`endif
) (
    input  logic                          clk,
    input  logic                          reset,
    paddle_button_conditioner_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE,
        HOLD_UP,
        HOLD_DN,
        WAIT_REL
    } state_t;

    // Index 0 is the up button, index 1 the down button throughout.
    logic [1:0]  raw;
    logic [1:0]  sync_a;
    logic [1:0]  sync_b;
    logic [1:0]  db;
    logic [1:0]  db_next;
    logic [15:0] db_cnt [2];

    logic        up_lvl;
    logic        dn_lvl;

    state_t      state;
    state_t      state_next;
    logic        up_q;
    logic        down_q;
    logic        up_next;
    logic        down_next;

`ifdef PADDLE_AUTO_REPEAT_EN
    logic [23:0] rep_ctr;
    logic [23:0] rep_ctr_next;
`endif

    assign raw = {bus.btn_down, bus.btn_up};

    // Two-flop synchroniser; only sync_b feeds any further logic.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_a <= 2'b00;
            sync_b <= 2'b00;
        end else begin
            sync_a <= raw;
            sync_b <= sync_a;
        end
    end

    // Debounced level about to be registered. The FSM steers on this
    // value so that the first pulse and the held level change together.
    always_comb begin
        db_next = db;
        for (int i = 0; i < 2; i++) begin
            if ((sync_b[i] != db[i]) && (db_cnt[i] >= DEBOUNCE_CYCLES)) begin
                db_next[i] = sync_b[i];
            end
        end
    end

    // Debounce counters: cleared whenever the synchronised level agrees
    // with the debounced one or a change is accepted, otherwise counting
    // up and saturating rather than wrapping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            db        <= 2'b00;
            db_cnt[0] <= 16'd0;
            db_cnt[1] <= 16'd0;
        end else begin
            db <= db_next;
            for (int i = 0; i < 2; i++) begin
                if ((sync_b[i] == db[i]) || (db_cnt[i] >= DEBOUNCE_CYCLES)) begin
                    db_cnt[i] <= 16'd0;
                end else if (db_cnt[i] != 16'hFFFF) begin
                    db_cnt[i] <= db_cnt[i] + 16'd1;
                end
            end
        end
    end

    assign up_lvl = db_next[0];
    assign dn_lvl = db_next[1];

    // State register plus the registered command pulses and repeat counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            up_q    <= 1'b0;
            down_q  <= 1'b0;
`ifdef PADDLE_AUTO_REPEAT_EN
            rep_ctr <= 24'd0;
`endif
        end else begin
            state   <= state_next;
            up_q    <= up_next;
            down_q  <= down_next;
`ifdef PADDLE_AUTO_REPEAT_EN
            rep_ctr <= rep_ctr_next;
`endif
        end
    end

    // Next-state logic. A conflicting press from either state parks the
    // machine in WAIT_REL, which only exits once both buttons are up.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (up_lvl && !dn_lvl) begin
                    state_next = HOLD_UP;
                end else if (dn_lvl && !up_lvl) begin
                    state_next = HOLD_DN;
                end else if (up_lvl && dn_lvl) begin
                    state_next = WAIT_REL;
                end
            end
            HOLD_UP: begin
                if (!up_lvl) begin
                    state_next = IDLE;
                end else if (dn_lvl) begin
                    state_next = WAIT_REL;
                end
            end
            HOLD_DN: begin
                if (!dn_lvl) begin
                    state_next = IDLE;
                end else if (up_lvl) begin
                    state_next = WAIT_REL;
                end
            end
            WAIT_REL: begin
                if (!up_lvl && !dn_lvl) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

`ifdef PADDLE_AUTO_REPEAT_EN
    // Output logic with auto-repeat. The counter is loaded on the first
    // pulse and counts down while the button stays the sole one held;
    // reaching 1 fires a repeat and reloads the shorter repeat period.
    always_comb begin
        up_next      = 1'b0;
        down_next    = 1'b0;
        rep_ctr_next = rep_ctr;
        case (state)
            IDLE: begin
                if (up_lvl && !dn_lvl) begin
                    up_next      = 1'b1;
                    rep_ctr_next = REPEAT_DELAY;
                end else if (dn_lvl && !up_lvl) begin
                    down_next    = 1'b1;
                    rep_ctr_next = REPEAT_DELAY;
                end
            end
            HOLD_UP: begin
                if (up_lvl && !dn_lvl) begin
                    if (rep_ctr == 24'd1) begin
                        up_next      = 1'b1;
                        rep_ctr_next = REPEAT_RATE;
                    end else if (rep_ctr != 24'd0) begin
                        rep_ctr_next = rep_ctr - 24'd1;
                    end
                end
            end
            HOLD_DN: begin
                if (dn_lvl && !up_lvl) begin
                    if (rep_ctr == 24'd1) begin
                        down_next    = 1'b1;
                        rep_ctr_next = REPEAT_RATE;
                    end else if (rep_ctr != 24'd0) begin
                        rep_ctr_next = rep_ctr - 24'd1;
                    end
                end
            end
            default: begin
                rep_ctr_next = rep_ctr;
            end
        endcase
    end
`else
    // Output logic without auto-repeat: only the IDLE exit pulses, so a
    // held button yields exactly one command.
    always_comb begin
        up_next   = 1'b0;
        down_next = 1'b0;
        if (state == IDLE) begin
            if (up_lvl && !dn_lvl) begin
                up_next = 1'b1;
            end else if (dn_lvl && !up_lvl) begin
                down_next = 1'b1;
            end
        end
    end
`endif

    assign bus.up   = up_q;
    assign bus.down = down_q;
    assign bus.held = db;

endmodule

// File: tb/tb_paddle_button_conditioner.sv
// ----------------------------------------------------------------------------
// tb_paddle_button_conditioner
//
// Purpose:
//   Self-checking bench for paddle_button_conditioner with
//   DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3. Directed scenarios
//   (clean press, bounce, conflict, simultaneous press, reset mid-press)
//   are followed by random button activity. A reference model predicts
//   debounced levels and command pulses; predicted pulses go into a queue
//   that a separate monitor drains whenever the design emits a pulse.
//   Follows PADDLE_AUTO_REPEAT_EN the same way the design does.
// ----------------------------------------------------------------------------
module tb_paddle_button_conditioner;

    localparam int DB_CYCLES = 4;
    localparam int REP_DELAY = 10;
    localparam int REP_RATE  = 3;
    localparam int HIST_LEN  = DB_CYCLES + 3;
`ifdef PADDLE_AUTO_REPEAT_EN
    localparam bit REPEAT_EN = 1'b1;
`else
    localparam bit REPEAT_EN = 1'b0;
`endif

    typedef enum int {OWN_NONE, OWN_UP, OWN_DN, OWN_BOTH} owner_t;

    typedef struct {
        bit is_up;
        int edge_no;
    } pulse_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    paddle_button_conditioner_if bus ();

    paddle_button_conditioner #(
        .DEBOUNCE_CYCLES(16'd4)
`ifdef PADDLE_AUTO_REPEAT_EN
        ,
        .REPEAT_DELAY   (24'd10),
        .REPEAT_RATE    (24'd3)
`endif
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int     checks = 0;
    int     fails  = 0;
    int     edge_cnt = 0;
    bit     hist_up[$];
    bit     hist_dn[$];
    bit     m_up_db = 1'b0;
    bit     m_dn_db = 1'b0;
    owner_t owner = OWN_NONE;
    int     press_edge = 0;
    pulse_t exp_q[$];

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d (edge %0d)",
                     name, actual, expected, edge_cnt);
        end
    endtask

    task automatic apply_stimulus(input bit u, input bit d, input int n);
        bus.btn_up   = u;
        bus.btn_down = d;
        repeat (n) @(negedge clk);
    endtask

    // A level is accepted once the button has read the same value for
    // DB_CYCLES+1 consecutive samples, ending two samples ago (the
    // synchroniser delay). Returns -1 when the window is not uniform.
    function automatic int stable_level(input bit h[$]);
        for (int i = 1; i <= DB_CYCLES; i++) begin
            if (h[i] != h[0]) return -1;
        end
        return int'(h[0]);
    endfunction

    // Auto-repeat pulses come REP_DELAY edges after the press pulse and
    // then every REP_RATE edges.
    function automatic bit repeat_due(input int elapsed);
        if (elapsed == REP_DELAY) return 1'b1;
        if (elapsed > REP_DELAY && ((elapsed - REP_DELAY) % REP_RATE) == 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void expect_pulse(input bit is_up, input int k);
        pulse_t p;
        p.is_up   = is_up;
        p.edge_no = k;
        exp_q.push_back(p);
    endfunction

    // Reference model, evaluated on each rising edge.
    always @(posedge clk) begin : ref_model
        int lu;
        int ld;
        if (!reset) begin
            hist_up.delete();
            hist_dn.delete();
            for (int i = 0; i < HIST_LEN; i++) begin
                hist_up.push_back(1'b0);
                hist_dn.push_back(1'b0);
            end
            m_up_db = 1'b0;
            m_dn_db = 1'b0;
            owner   = OWN_NONE;
        end else begin
            hist_up.push_back(bus.btn_up);
            hist_dn.push_back(bus.btn_down);
            while (hist_up.size() > HIST_LEN) void'(hist_up.pop_front());
            while (hist_dn.size() > HIST_LEN) void'(hist_dn.pop_front());
            lu = stable_level(hist_up);
            ld = stable_level(hist_dn);
            if (lu >= 0) m_up_db = (lu == 1);
            if (ld >= 0) m_dn_db = (ld == 1);
            case (owner)
                OWN_NONE: begin
                    if (m_up_db && !m_dn_db) begin
                        expect_pulse(1'b1, edge_cnt);
                        owner = OWN_UP;
                        press_edge = edge_cnt;
                    end else if (m_dn_db && !m_up_db) begin
                        expect_pulse(1'b0, edge_cnt);
                        owner = OWN_DN;
                        press_edge = edge_cnt;
                    end else if (m_up_db && m_dn_db) begin
                        owner = OWN_BOTH;
                    end
                end
                OWN_UP: begin
                    if (!m_up_db) owner = OWN_NONE;
                    else if (m_dn_db) owner = OWN_BOTH;
                    else if (REPEAT_EN && repeat_due(edge_cnt - press_edge))
                        expect_pulse(1'b1, edge_cnt);
                end
                OWN_DN: begin
                    if (!m_dn_db) owner = OWN_NONE;
                    else if (m_up_db) owner = OWN_BOTH;
                    else if (REPEAT_EN && repeat_due(edge_cnt - press_edge))
                        expect_pulse(1'b0, edge_cnt);
                end
                default: begin
                    if (!m_up_db && !m_dn_db) owner = OWN_NONE;
                end
            endcase
        end
        edge_cnt++;
    end

    // Monitor: on each falling edge compare held, exclusivity, and any
    // pulse against the head of the expectation queue.
    always @(negedge clk) begin : monitor
        pulse_t p;
        if (reset) begin
            check_output("held", {30'd0, bus.held}, {30'd0, m_dn_db, m_up_db});
            check_output("exclusive", {31'd0, bus.up & bus.down}, 32'd0);
            while (exp_q.size() > 0 && exp_q[0].edge_no + 1 < edge_cnt) begin
                p = exp_q.pop_front();
                checks++;
                fails++;
                $display("[TB] FAIL missed_pulse: got none, expected %s pulse after edge %0d",
                         p.is_up ? "up" : "down", p.edge_no);
            end
            if (bus.up || bus.down) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("[TB] FAIL unexpected_pulse: got up=%0b down=%0b after edge %0d, expected none",
                             bus.up, bus.down, edge_cnt - 1);
                end else begin
                    p = exp_q.pop_front();
                    check_output("pulse_dir", {31'd0, bus.up}, {31'd0, p.is_up});
                    check_output("pulse_time", edge_cnt, p.edge_no + 1);
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        fails++;
        $display("End of test - %0d assertions evaluated, %0d failures", checks + 1, fails);
        $fatal(1, "[TB] timeout");
    end

    initial begin : stimulus
        bit u;
        bit d;
        int n;
        bus.btn_up   = 1'b0;
        bus.btn_down = 1'b0;
        reset        = 1'b0;
        repeat (3) @(negedge clk);
        check_output("reset_held", {30'd0, bus.held}, 32'd0);
        reset = 1'b1;

        $display("[TB] clean press");
        apply_stimulus(1'b1, 1'b0, 30);
        apply_stimulus(1'b0, 1'b0, 15);

        $display("[TB] bounce");
        for (int i = 0; i < 10; i++) begin
            apply_stimulus(i % 2 == 0, 1'b0, 2);
        end
        apply_stimulus(1'b0, 1'b0, 15);

        $display("[TB] conflict");
        apply_stimulus(1'b1, 1'b0, 20);
        apply_stimulus(1'b1, 1'b1, 30);
        apply_stimulus(1'b0, 1'b0, 15);
        apply_stimulus(1'b0, 1'b1, 20);
        apply_stimulus(1'b0, 1'b0, 15);

        $display("[TB] simultaneous");
        apply_stimulus(1'b1, 1'b1, 30);
        apply_stimulus(1'b0, 1'b0, 15);

        $display("[TB] reset mid-press");
        apply_stimulus(1'b1, 1'b0, 22);
        #2;
        reset = 1'b0;
        #1;
        check_output("reset_up", {31'd0, bus.up}, 32'd0);
        check_output("reset_down", {31'd0, bus.down}, 32'd0);
        check_output("reset_mid_held", {30'd0, bus.held}, 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        apply_stimulus(1'b1, 1'b0, 25);
        apply_stimulus(1'b0, 1'b0, 15);

        $display("[TB] random activity");
        for (int s = 0; s < 60; s++) begin
            u = 1'($urandom_range(0, 1));
            d = ($urandom_range(0, 3) == 0);
            n = (($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 30));
            apply_stimulus(u, d, n);
        end
        apply_stimulus(1'b0, 1'b0, 25);

        check_output("queue_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
